// File: rtl/cv32e40p_instr_mem_responder.sv
// OBI-style instruction-memory responder: fixed-latency, in-order read responses with side-band preload.
// Optional IMEM_RAND_GNT_EN build masks grants with a 16-bit LFSR to exercise fetch stalls.
module cv32e40p_instr_mem_responder #(
  parameter int MEM_WORDS       = 16384,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic [2:0]  outstanding_o,
  output logic        misalign_err_o,
  output logic        range_err_o
);

  localparam int          AW     = $clog2(MEM_WORDS);
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic [31:0]        mem [MEM_WORDS];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];
  logic [2:0]         cnt_q, cnt_d;
  logic               mis_q, mis_d;
  logic               rng_q, rng_d;

  logic [29:0] rd_idx, ld_idx;
  logic        rd_in_range, ld_in_range;
  logic [31:0] rd_word;
  logic        accept, retire, cap_ok, rand_ok;
  logic        unused_load_lsbs;

  assign rd_idx           = instr_addr_i[31:2];
  assign ld_idx           = load_addr_i[31:2];
  assign rd_in_range      = rd_idx < 30'(MEM_WORDS);
  assign ld_in_range      = ld_idx < 30'(MEM_WORDS);
  assign unused_load_lsbs = ^load_addr_i[1:0];

`ifdef IMEM_RAND_GNT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; free-running so stall pattern is independent of traffic
  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = {lfsr_q[14:0], lfsr_fb};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign rand_ok = |lfsr_q[1:0];
`else
  assign rand_ok = 1'b1;
`endif

  // A tail entry retiring this cycle frees its slot for a same-cycle grant
  assign retire      = vld_q[LATENCY-1];
  assign cap_ok      = (cnt_q < 3'(MAX_OUTSTANDING)) || retire;
  assign instr_gnt_o = instr_req_i && cap_ok && rand_ok;
  assign accept      = instr_gnt_o;

  // Combinational array read happens before the edge, giving read-before-write on collisions
  assign rd_word = rd_in_range ? mem[rd_idx[AW-1:0]] : NOP_W;

  always_comb begin
    vld_d[0]  = accept;
    data_d[0] = rd_word;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    cnt_d = cnt_q + {2'b00, accept} - {2'b00, retire};
    mis_d = mis_q | (accept & (|instr_addr_i[1:0]));
    rng_d = rng_q | (accept & ~rd_in_range);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= 3'd0;
      mis_q <= 1'b0;
      rng_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      rng_q <= rng_d;
    end
  end

  // Payload carries no reset; rdata is qualified by the valid bit instead
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
  end

  always_ff @(posedge clk_i) begin
    if (load_we_i && ld_in_range) mem[ld_idx[AW-1:0]] <= load_wdata_i;
  end

  assign instr_rvalid_o = vld_q[LATENCY-1];
  assign instr_rdata_o  = vld_q[LATENCY-1] ? data_q[LATENCY-1] : 32'h0;
  assign outstanding_o  = cnt_q;
  assign misalign_err_o = mis_q;
  assign range_err_o    = rng_q;

endmodule

// File: tb/tb_cv32e40p_instr_mem_responder.sv
// Directed bench for cv32e40p_instr_mem_responder: four instances cover the latency/outstanding configurations.
module tb_cv32e40p_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0, load_wdata = '0;

  logic        req1 = 0, req2 = 0, req3 = 0, req4 = 0;
  logic [31:0] addr1 = '0, addr2 = '0, addr3 = '0, addr4 = '0;
  logic        gnt1, gnt2, gnt3, gnt4;
  logic        rv1, rv2, rv3, rv4;
  logic [31:0] rd1, rd2, rd3, rd4;
  logic [2:0]  os1, os2, os3, os4;
  logic        me1, me2, me3, me4;
  logic        re1, re2, re3, re4;

  int checks = 0;
  int failures = 0;

  logic [31:0] words [4] = '{32'h0010_0093, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  always #5 clk = ~clk;

  cv32e40p_instr_mem_responder #(.MEM_WORDS(16384), .LATENCY(1), .MAX_OUTSTANDING(2)) u1 (
    .clk_i(clk), .rst_n(rst_n), .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
    .instr_rvalid_o(rv1), .instr_rdata_o(rd1), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(os1), .misalign_err_o(me1), .range_err_o(re1));

  cv32e40p_instr_mem_responder #(.MEM_WORDS(16384), .LATENCY(2), .MAX_OUTSTANDING(3)) u2 (
    .clk_i(clk), .rst_n(rst_n), .instr_req_i(req2), .instr_addr_i(addr2), .instr_gnt_o(gnt2),
    .instr_rvalid_o(rv2), .instr_rdata_o(rd2), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(os2), .misalign_err_o(me2), .range_err_o(re2));

  cv32e40p_instr_mem_responder #(.MEM_WORDS(16384), .LATENCY(3), .MAX_OUTSTANDING(1)) u3 (
    .clk_i(clk), .rst_n(rst_n), .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
    .instr_rvalid_o(rv3), .instr_rdata_o(rd3), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(os3), .misalign_err_o(me3), .range_err_o(re3));

  cv32e40p_instr_mem_responder #(.MEM_WORDS(16384), .LATENCY(3), .MAX_OUTSTANDING(2)) u4 (
    .clk_i(clk), .rst_n(rst_n), .instr_req_i(req4), .instr_addr_i(addr4), .instr_gnt_o(gnt4),
    .instr_rvalid_o(rv4), .instr_rdata_o(rd4), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(os4), .misalign_err_o(me4), .range_err_o(re4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_wdata = d;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", {31'b0, gnt1}, 32'd0);
    chk("rst_rvalid", {31'b0, rv4}, 32'd0);
    chk("rst_rdata", rd4, 32'h0);
    chk("rst_outstanding", {29'b0, os4}, 32'd0);
    chk("rst_misalign", {31'b0, me4}, 32'd0);
    chk("rst_range", {31'b0, re4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload, including an out-of-range write that must be dropped
    for (int i = 0; i < 4; i++) load(32'(4 * i), words[i]);
    load(32'd20, 32'hAAAA_AAAA);
    load(32'd65536, 32'hDEAD_BEEF);
    @(negedge clk);
    load_we = 1'b0;

    // LATENCY=1 single fetch
    req1 = 1'b1; addr1 = 32'd0;
    #1;
    chk("t1_gnt", {31'b0, gnt1}, 32'd1);
    chk("t1_rvalid_c0", {31'b0, rv1}, 32'd0);
    @(negedge clk);
    req1 = 1'b0;
    #1;
    chk("t1_rvalid_c1", {31'b0, rv1}, 32'd1);
    chk("t1_rdata_c1", rd1, 32'h0010_0093);
    chk("t1_outstanding_c1", {29'b0, os1}, 32'd1);
    @(negedge clk);
    #1;
    chk("t1_rvalid_c2", {31'b0, rv1}, 32'd0);
    chk("t1_rdata_c2", rd1, 32'h0);
    chk("t1_outstanding_c2", {29'b0, os1}, 32'd0);

    // LATENCY=2 back-to-back burst
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req2 = (c < 4);
      addr2 = 32'(4 * c);
      #1;
      if (c < 4) chk("t2_gnt", {31'b0, gnt2}, 32'd1);
      chk("t2_rvalid", {31'b0, rv2}, {31'b0, (c >= 2 && c <= 5)});
      chk("t2_rdata", rd2, (c >= 2 && c <= 5) ? words[c-2] : 32'h0);
    end
    req2 = 1'b0;

    // LATENCY=3, MAX_OUTSTANDING=1: one grant every third cycle
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req3 = 1'b1; addr3 = 32'd0;
      #1;
      chk("t3_gnt", {31'b0, gnt3}, {31'b0, (c % 3 == 0)});
      chk("t3_outstanding", {29'b0, os3}, (c == 0) ? 32'd0 : 32'd1);
      chk("t3_rvalid", {31'b0, rv3}, {31'b0, (c == 3 || c == 6)});
    end
    @(negedge clk);
    req3 = 1'b0;

    // Misaligned and out-of-range fetches
    @(negedge clk);
    req4 = 1'b1; addr4 = 32'h0000_0006;
    #1;
    chk("t4_gnt_mis", {31'b0, gnt4}, 32'd1);
    @(negedge clk);
    addr4 = 32'd65536;
    #1;
    chk("t4_gnt_rng", {31'b0, gnt4}, 32'd1);
    chk("t4_misalign_set", {31'b0, me4}, 32'd1);
    @(negedge clk);
    req4 = 1'b0;
    #1;
    chk("t4_range_set", {31'b0, re4}, 32'd1);
    chk("t4_outstanding", {29'b0, os4}, 32'd2);
    @(negedge clk);
    #1;
    chk("t4_rvalid_mis", {31'b0, rv4}, 32'd1);
    chk("t4_rdata_mis", rd4, 32'h1111_1111);
    @(negedge clk);
    #1;
    chk("t4_rvalid_rng", {31'b0, rv4}, 32'd1);
    chk("t4_rdata_rng", rd4, 32'h0000_0013);
    @(negedge clk);
    #1;
    chk("t4_rvalid_idle", {31'b0, rv4}, 32'd0);
    chk("t4_outstanding_idle", {29'b0, os4}, 32'd0);

    // Same-edge preload and fetch of word 5
    @(negedge clk);
    req1 = 1'b1; addr1 = 32'd20;
    load_we = 1'b1; load_addr = 32'd20; load_wdata = 32'hBBBB_BBBB;
    #1;
    chk("t5_gnt_collide", {31'b0, gnt1}, 32'd1);
    @(negedge clk);
    load_we = 1'b0;
    #1;
    chk("t5_gnt_next", {31'b0, gnt1}, 32'd1);
    chk("t5_rdata_old", rd1, 32'hAAAA_AAAA);
    @(negedge clk);
    req1 = 1'b0;
    #1;
    chk("t5_rdata_new", rd1, 32'hBBBB_BBBB);

    // Mid-flight reset drops in-flight responses and clears sticky errors
    @(negedge clk);
    req4 = 1'b1; addr4 = 32'd0;
    #1;
    chk("t6_gnt0", {31'b0, gnt4}, 32'd1);
    @(negedge clk);
    addr4 = 32'd4;
    #1;
    chk("t6_gnt1", {31'b0, gnt4}, 32'd1);
    @(negedge clk);
    req4 = 1'b0;
    #1;
    chk("t6_outstanding_pre", {29'b0, os4}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_outstanding_rst", {29'b0, os4}, 32'd0);
    chk("t6_misalign_rst", {31'b0, me4}, 32'd0);
    chk("t6_range_rst", {31'b0, re4}, 32'd0);
    chk("t6_rvalid_rst", {31'b0, rv4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("t6_rvalid_post", {31'b0, rv4}, 32'd0);
      chk("t6_outstanding_post", {29'b0, os4}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
